// File: rtl/watermark_pkg.sv
// Shared types and defaults for the LSB watermark embedder.
// bits_left is sized to hold the values 0..MSG_W inclusive.
package watermark_pkg;

  localparam int DEF_PIX_W   = 8;
  localparam int DEF_NCH     = 3;
  localparam int DEF_NBITS   = 1;
  localparam int DEF_MSG_W   = 8;
  localparam int DEF_OVERCLK = 5;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } wm_state_e;

  function automatic int bl_width(input int msg_w);
    return $clog2(msg_w + 1);
  endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Phase counter that turns clk_enable into one processing tick every OVERCLK enables.
// The first edge after reset release only arms the counter, so no tick happens in the release cycle.
module wm_tick_gen #(
  parameter int OVERCLK = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  output logic tick
);

  localparam int PW = $clog2(OVERCLK + 1);

  logic          running;
  logic [PW-1:0] phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      phase   <= PW'(1);
    end else if (!running) begin
      running <= 1'b1;
    end else if (clk_enable) begin
      phase <= (phase == PW'(OVERCLK)) ? PW'(1) : phase + PW'(1);
    end
  end

  assign tick = running && clk_enable && (phase == PW'(1));

endmodule

// File: rtl/watermark_embedder.sv
// Replaces the low NBITS of each pixel channel with buffered message bits, LSB-first,
// consuming one pixel per tick; a new word is accepted only once the buffer is empty or draining.
module watermark_embedder
  import watermark_pkg::*;
#(
  parameter int PIX_W   = DEF_PIX_W,
  parameter int NCH     = DEF_NCH,
  parameter int NBITS   = DEF_NBITS,
  parameter int MSG_W   = DEF_MSG_W,
  parameter int OVERCLK = DEF_OVERCLK
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_enable,
  input  logic                          embed_en,
  input  logic                          pix_valid,
  input  logic [NCH*PIX_W-1:0]          pixel,
  input  logic                          msg_valid,
  input  logic [MSG_W-1:0]              message,
  output logic                          msg_ready,
  output logic [NCH*PIX_W-1:0]          pixel_out,
  output logic                          pixel_out_valid,
  output logic                          embedded,
  output logic [bl_width(MSG_W)-1:0]    bits_left
);

  localparam int BLW       = bl_width(MSG_W);
  localparam int SLOT_BITS = NCH * NBITS;

  wm_state_e                   state;
  logic [MSG_W-1:0]            msg_buf;
  logic [SLOT_BITS+MSG_W-1:0]  buf_ext;
  logic                        tick;
  logic                        embed_active;
  logic                        drain_all;
  logic [BLW-1:0]              take;
  logic [NCH*PIX_W-1:0]        pix_next;

  wm_tick_gen #(.OVERCLK(OVERCLK)) u_tick (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .tick       (tick)
  );

  assign embed_active = tick && pix_valid && embed_en && (state == LOADED);
  assign drain_all    = embed_active && (int'(bits_left) <= SLOT_BITS);
  assign msg_ready    = tick && ((state == EMPTY) || drain_all);
  assign take         = (int'(bits_left) < SLOT_BITS) ? bits_left : BLW'(SLOT_BITS);
  // Zero padding lets the slot loop index past the end of a short final word safely.
  assign buf_ext      = {{SLOT_BITS{1'b0}}, msg_buf};

  always_comb begin
    pix_next = pixel;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int b = 0; b < NBITS; b++) begin
        if (embed_active && ((ch * NBITS + b) < int'(bits_left))) begin
          pix_next[ch*PIX_W+b] = buf_ext[ch*NBITS+b];
        end
      end
    end
  end

  // A load on a draining tick wins, so the new word only affects later pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= EMPTY;
      msg_buf         <= '0;
      bits_left       <= '0;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      embedded        <= 1'b0;
    end else begin
      pixel_out_valid <= tick && pix_valid;
      if (tick) begin
        if (pix_valid) begin
          pixel_out <= pix_next;
          embedded  <= embed_active;
        end
        if (msg_valid && msg_ready) begin
          msg_buf   <= message;
          bits_left <= BLW'(MSG_W);
          state     <= LOADED;
        end else if (embed_active) begin
          msg_buf   <= msg_buf >> take;
          bits_left <= bits_left - take;
          if (drain_all) begin
            state <= EMPTY;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_watermark_embedder.sv
// Drives three embedder configurations from shared stimulus and checks them against a bit-level model.
// Instances: 0 = NBITS 1 / OVERCLK 1, 1 = NBITS 2 / OVERCLK 1, 2 = NBITS 1 / OVERCLK 5.
module tb_watermark_embedder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        embed_en = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pixel = '0;
  logic        msg_valid = 1'b0;
  logic [7:0]  message = '0;

  logic        rdy_o [3];
  logic [23:0] pix_o [3];
  logic        val_o [3];
  logic        emb_o [3];
  logic [3:0]  bl_o  [3];

  int total = 0;
  int bad   = 0;

  bit          m_run   [3];
  int          m_cnt   [3];
  int          m_left  [3];
  logic [7:0]  m_msg   [3];
  logic [23:0] m_pix   [3];
  bit          m_valid [3];
  bit          m_emb   [3];
  bit          m_ready [3];

  int pulses;

  always #5 clk = ~clk;

  watermark_embedder #(.PIX_W(8), .NCH(3), .NBITS(1), .MSG_W(8), .OVERCLK(1)) dut0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .embed_en(embed_en),
    .pix_valid(pix_valid), .pixel(pixel), .msg_valid(msg_valid), .message(message),
    .msg_ready(rdy_o[0]), .pixel_out(pix_o[0]), .pixel_out_valid(val_o[0]),
    .embedded(emb_o[0]), .bits_left(bl_o[0])
  );

  watermark_embedder #(.PIX_W(8), .NCH(3), .NBITS(2), .MSG_W(8), .OVERCLK(1)) dut1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .embed_en(embed_en),
    .pix_valid(pix_valid), .pixel(pixel), .msg_valid(msg_valid), .message(message),
    .msg_ready(rdy_o[1]), .pixel_out(pix_o[1]), .pixel_out_valid(val_o[1]),
    .embedded(emb_o[1]), .bits_left(bl_o[1])
  );

  watermark_embedder #(.PIX_W(8), .NCH(3), .NBITS(1), .MSG_W(8), .OVERCLK(5)) dut2 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .embed_en(embed_en),
    .pix_valid(pix_valid), .pixel(pixel), .msg_valid(msg_valid), .message(message),
    .msg_ready(rdy_o[2]), .pixel_out(pix_o[2]), .pixel_out_valid(val_o[2]),
    .embedded(emb_o[2]), .bits_left(bl_o[2])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_cnt[i] = 0; m_left[i] = 0; m_msg[i] = '0;
      m_pix[i] = '0; m_valid[i] = 0; m_emb[i] = 0; m_ready[i] = 0;
    end
  endtask

  // Message held as a word plus a count; bits are popped one at a time into successive slots.
  task automatic model_step(input int i);
    int nb, oc;
    bit tk, e;
    logic [23:0] o;
    nb = (i == 1) ? 2 : 1;
    oc = (i == 2) ? 5 : 1;
    tk = m_run[i] && clk_enable && ((m_cnt[i] % oc) == 0);
    m_ready[i] = tk && (m_left[i] == 0 || (pix_valid && embed_en && m_left[i] <= 3 * nb));
    m_valid[i] = tk && pix_valid;
    if (tk && pix_valid) begin
      o = pixel;
      e = 0;
      if (embed_en) begin
        for (int ch = 0; ch < 3; ch++) begin
          for (int b = 0; b < nb; b++) begin
            if (m_left[i] > 0) begin
              o[ch*8+b] = m_msg[i][0];
              m_msg[i] = m_msg[i] >> 1;
              m_left[i]--;
              e = 1;
            end
          end
        end
      end
      m_pix[i] = o;
      m_emb[i] = e;
    end
    if (tk && msg_valid && m_ready[i]) begin
      m_msg[i]  = message;
      m_left[i] = 8;
    end
    if (!m_run[i]) m_run[i] = 1;
    else if (clk_enable) m_cnt[i]++;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic applyStimulus();
    #1;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      checkOutput($sformatf("ready%0d", i), rdy_o[i], m_ready[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("pix%0d", i),   pix_o[i], m_pix[i]);
      checkOutput($sformatf("valid%0d", i), val_o[i], m_valid[i]);
      checkOutput($sformatf("emb%0d", i),   emb_o[i], m_emb[i]);
      checkOutput($sformatf("left%0d", i),  bl_o[i],  m_left[i]);
    end
    @(negedge clk);
  endtask

  task automatic set_inputs(input logic ce, input logic ee, input logic pv, input logic [23:0] px,
                            input logic mv, input logic [7:0] msg);
    clk_enable = ce; embed_en = ee; pix_valid = pv; pixel = px; msg_valid = mv; message = msg;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_pix%0d", i),   pix_o[i], 0);
      checkOutput($sformatf("rst_valid%0d", i), val_o[i], 0);
      checkOutput($sformatf("rst_emb%0d", i),   emb_o[i], 0);
      checkOutput($sformatf("rst_left%0d", i),  bl_o[i],  0);
      checkOutput($sformatf("rst_ready%0d", i), rdy_o[i], 0);
    end
    @(negedge clk);
    reset = 1'b1;
    set_inputs(1, 0, 0, 24'h0, 0, 8'h0);
    applyStimulus();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 0xA5 spread over four black pixels, one bit per channel.
    set_inputs(1, 1, 0, 24'h0, 1, 8'hA5);
    applyStimulus();
    set_inputs(1, 1, 1, 24'h000000, 0, 8'h00);
    applyStimulus();
    checkOutput("a5_pix1", pix_o[0], 24'h010001);
    checkOutput("a5_left1", bl_o[0], 5);
    applyStimulus();
    checkOutput("a5_pix2", pix_o[0], 24'h010000);
    applyStimulus();
    checkOutput("a5_pix3", pix_o[0], 24'h000100);
    checkOutput("a5_left3", bl_o[0], 0);
    applyStimulus();
    checkOutput("a5_pix4", pix_o[0], 24'h000000);
    checkOutput("a5_emb4", emb_o[0], 0);

    // Drain and reload in the same tick with msg_valid held.
    do_reset();
    set_inputs(1, 1, 0, 24'h0, 1, 8'hFF);
    applyStimulus();
    set_inputs(1, 1, 1, 24'hFFFFFF, 1, 8'h00);
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("reload_ready", rdy_o[0], 1);
    applyStimulus();
    checkOutput("reload_pix3", pix_o[0], 24'hFFFFFF);
    checkOutput("reload_emb3", emb_o[0], 1);
    applyStimulus();
    checkOutput("reload_pix4", pix_o[0], 24'hFEFEFE);

    // Pass-through keeps the buffer intact.
    do_reset();
    set_inputs(1, 0, 0, 24'h0, 1, 8'h3C);
    applyStimulus();
    set_inputs(1, 0, 1, 24'h123456, 0, 8'h00);
    applyStimulus();
    checkOutput("bypass_pix", pix_o[0], 24'h123456);
    checkOutput("bypass_emb", emb_o[0], 0);
    checkOutput("bypass_left", bl_o[0], 8);

    // Reset mid-message, then the first tick must act as empty.
    do_reset();
    set_inputs(1, 1, 0, 24'h0, 1, 8'hA5);
    applyStimulus();
    set_inputs(1, 1, 1, 24'h0, 0, 8'h00);
    applyStimulus();
    checkOutput("mid_left", bl_o[0], 5);
    do_reset();
    set_inputs(1, 1, 1, 24'h0F0F0F, 0, 8'h00);
    #1;
    checkOutput("post_rst_ready", rdy_o[0], 1);
    applyStimulus();
    checkOutput("post_rst_pix", pix_o[0], 24'h0F0F0F);
    checkOutput("post_rst_emb", emb_o[0], 0);

    // Two bits per slot with a short final slot.
    do_reset();
    set_inputs(1, 1, 0, 24'h0, 1, 8'hE4);
    applyStimulus();
    set_inputs(1, 1, 1, 24'hFFFFFF, 0, 8'h00);
    applyStimulus();
    checkOutput("nb2_pix1", pix_o[1], 24'hFEFDFC);
    checkOutput("nb2_left1", bl_o[1], 2);
    applyStimulus();
    checkOutput("nb2_pix2", pix_o[1], 24'hFFFFFF);
    checkOutput("nb2_left2", bl_o[1], 0);

    // Tick every five enabled clocks.
    do_reset();
    set_inputs(1, 0, 1, 24'h555555, 0, 8'h00);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      if (c == 0) checkOutput("oc5_first", val_o[2], 1);
      if (val_o[2]) pulses++;
    end
    checkOutput("oc5_pulses", pulses, 4);

    // Random traffic, occasionally resetting.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      set_inputs($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7,
                 24'($urandom), $urandom_range(0, 9) < 4, 8'($urandom));
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watermark_embedder.md
WATERMARK_EMBEDDER -- requirements
Module: watermark_embedder

Interface
REQ-001 Parameter PIX_W, default 8, bits per colour channel.
REQ-002 Parameter NCH, default 3, channels per pixel, range 1..4.
REQ-003 Parameter NBITS, default 1, LSBs replaced per channel, range 1..PIX_W/2.
REQ-004 Parameter MSG_W, default 8, message word width, at least 1.
REQ-005 Parameter OVERCLK, default 5, enabled clocks per processing tick, at least 1.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 clk_enable  in  1  global clock enable; when low, all state holds.
REQ-009 embed_en  in  1  1 = embed, 0 = pass-through; the message buffer holds.
REQ-010 pix_valid  in  1  input pixel is present; sampled on ticks only.
REQ-011 pixel  in  NCH*PIX_W  channel 0 in the least-significant PIX_W bits.
REQ-012 msg_valid  in  1  a message word is offered.
REQ-013 message  in  MSG_W  message word, consumed LSB-first.
REQ-014 msg_ready  out  1  the buffer accepts a word on this tick.
REQ-015 pixel_out  out  NCH*PIX_W  registered output pixel.
REQ-016 pixel_out_valid  out  1  pixel_out is new this tick.
REQ-017 embedded  out  1  at least one bit of pixel_out carries message data.
REQ-018 bits_left  out  $clog2(MSG_W+1)  message bits still buffered.

Function
REQ-019 Phase counter: reset value 1; increments on each clk_enable; wraps OVERCLK to 1. A tick is clk_enable AND phase==1.
REQ-020 All handshakes and state updates occur on ticks only. Between ticks, outputs hold except pixel_out_valid.
REQ-021 pixel_out_valid pulses for exactly one clock, the clock after a tick with pix_valid=1. Latency is 1 clock.
REQ-022 FSM states: EMPTY (bits_left=0) and LOADED (bits_left>0).
REQ-023 EMPTY→LOADED: on a tick with msg_valid AND msg_ready; bits_left:=MSG_W.
REQ-024 LOADED→EMPTY: on a tick where the last bits are consumed and no new word is loaded.
REQ-025 msg_ready = tick AND (state EMPTY, or the current tick consumes all remaining bits with pix_valid=1 AND embed_en=1).
REQ-026 Simultaneous drain and load: the new word replaces the buffer; bits_left:=MSG_W. The new bits apply from the next pixel, never the current one.
REQ-027 Embedding (embed_en=1, pix_valid=1, LOADED):
  - slot order is channel 0 upward; each slot takes the next NBITS message bits, LSB-first;
  - each slot replaces the low NBITS of its channel.
REQ-028 If bits_left < NBITS, the final slot is filled with the remaining bits, upper slot bits keep their pixel values, and bits_left:=0. Slots beyond that point pass unmodified.
REQ-029 bits_left decrements by min(bits_left, NCH*NBITS) per embedding pixel and never wraps below 0.
REQ-030 In EMPTY, when embed_en=0, or when pix_valid=0, no bits are consumed. Pixels pass unmodified with embedded=0.
REQ-031 Channel arithmetic is a bit replacement only: no carry, no saturation, and the upper PIX_W-NBITS bits are unchanged.

Reset
REQ-032 Reset values: pixel_out=0, pixel_out_valid=0, embedded=0, bits_left=0, FSM=EMPTY, phase=1, message buffer=0.
REQ-033 Reset asserted mid-message discards the buffered bits. The first tick after release behaves as EMPTY.
REQ-034 Reset deassertion takes effect at the next rising clk; no tick occurs in the release cycle.

Structure
REQ-035 Package watermark_pkg holds the FSM state enum, the default parameter constants and a width function for bits_left.
REQ-036 Sub-module wm_tick_gen is the phase counter and tick generator, parameterised by OVERCLK.
REQ-037 The top-level module holds the FSM, the message shift buffer and the slot-replace datapath.

Verification (PIX_W=8, NCH=3, NBITS=1, MSG_W=8, OVERCLK=1 unless stated)
REQ-038 message=0xA5 loaded, four pixels 0x000000, embed_en=1 → pixel_out values 0x010001, 0x010000, 0x000100, 0x000000; embedded=1,1,1,0; bits_left=5,2,0,0.
REQ-039 Load, drain and reload: msg_valid held with 0xFF then 0x00 over pixels 0xFFFFFF → the third pixel is 0xFFFFFF with embedded=1 and msg_ready=1; the fourth pixel uses 0x00 and gives 0xFEFEFE.
REQ-040 OVERCLK=5, clk_enable=1, pix_valid=1 continuously → pixel_out_valid pulses once every 5 clocks, first pulse 1 clock after the first tick.
REQ-041 embed_en=0 with 0x3C loaded, pixel 0x123456 → pixel_out=0x123456, embedded=0, bits_left stays 8.
REQ-042 Reset asserted with bits_left=5 → all outputs are zero immediately. After release, pixel 0x0F0F0F gives 0x0F0F0F, embedded=0, msg_ready=1.
REQ-043 NBITS=2, MSG_W=8, message 0xE4, pixel 0xFFFFFF → pixel_out=0xFEFDFC, bits_left=2. Next pixel gives 0xFFFFFF: channel 0 receives the remaining bits 11, bits_left=0.
